// File: rtl/pu_sequencer_pkg.sv
// Shared definitions for the processing-unit sequencer: FSM encoding, tag
// field layout and the pipeline stage numbers derived from the read latency.
package pu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int TAG_W     = 3;
  localparam int TAG_LAST  = 0;
  localparam int TAG_FIRST = 1;
  localparam int TAG_VALID = 2;

  localparam int RD_LAT_DEF = 1;

  // Stage numbers count cycles after the issue cycle (stage 1 = one cycle later).
  function automatic int tree_stage(input int rd_lat);
    return rd_lat + 32'sd2;
  endfunction

  function automatic int cap_stage(input int rd_lat);
    return rd_lat + 32'sd3;
  endfunction

  localparam int TREE_STAGE = tree_stage(RD_LAT_DEF);
  localparam int CAP_STAGE  = cap_stage(RD_LAT_DEF);

endpackage

// File: rtl/pu_sequencer_if.sv
// Result hand-off channel from the sequencer to the downstream consumer.
interface pu_sequencer_if;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/pu_sequencer_tag_pipe.sv
// Tag shift register tracking each issued chunk through the datapath pipeline.
// The first-tag chain only needs to reach the tree stage, so it is shorter.
module pu_tag_pipe
  import pu_sequencer_pkg::*;
#(
  parameter int DEPTH = CAP_STAGE,
  parameter int TAP   = TREE_STAGE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] tag_in,
  output logic             first_hit,
  output logic             last_hit
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;
  logic [TAP-1:0]   first_q, first_d;

  // Shift every chain by one stage per cycle.
  always_comb begin
    valid_d = {valid_q[DEPTH-2:0], tag_in[TAG_VALID]};
    last_d  = {last_q[DEPTH-2:0], tag_in[TAG_LAST]};
    first_d = {first_q[TAP-2:0], tag_in[TAG_FIRST]};
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      last_q  <= '0;
      first_q <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  assign first_hit = valid_q[TAP-1] & first_q[TAP-1];
  assign last_hit  = valid_q[DEPTH-1] & last_q[DEPTH-1];

endmodule

// File: rtl/pu_sequencer.sv
// Issues the operand chunks of one neuron, strobes bias/clr into the datapath
// and hands the activated result downstream over valid/ready.
module pu_sequencer
  import pu_sequencer_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_chunks,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              bias_sig,
  output logic              clr,
  input  logic [7:0]        result_in,
  pu_sequencer_if.master    out_if
);

  localparam int TREE_STG = tree_stage(RD_LAT);
  localparam int CAP_STG  = cap_stage(RD_LAT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [7:0]        data_q, data_d;
  logic [TAG_W-1:0]  tag_s;
  logic              first_hit_s, last_hit_s;

  // Next-state and registered-output computation for the neuron sequence.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    rd_en_d = rd_en_q;
    first_d = first_q;
    last_d  = last_q;
    valid_d = valid_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (num_chunks != '0)) begin
          state_d = ST_ISSUE;
          num_d   = num_chunks;
          idx_d   = '0;
          addr_d  = base_addr;
          rd_en_d = 1'b1;
          first_d = 1'b1;
          last_d  = (num_chunks == CNT_W'(1));
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (last_q) begin
          state_d = ST_DRAIN;
          rd_en_d = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          first_d = 1'b0;
          // Next issue is the last one when its index equals num-1.
          last_d  = ((idx_q + CNT_W'(2)) == num_q);
        end
      end
      ST_DRAIN: begin
        if (last_hit_s) begin
          state_d = ST_OUT;
          data_d  = result_in;
          valid_d = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_OUT: begin
        if (out_if.out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rd_en_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign tag_s = {rd_en_q, first_q, last_q};

  pu_tag_pipe #(
    .DEPTH (CAP_STG),
    .TAP   (TREE_STG)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (tag_s),
    .first_hit (first_hit_s),
    .last_hit  (last_hit_s)
  );

  assign busy             = busy_q;
  assign mem_rd_en        = rd_en_q;
  assign mem_addr         = addr_q;
  assign bias_sig         = first_hit_s;
  assign clr              = first_hit_s;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;

endmodule

// File: tb/tb_pu_sequencer.sv
// Self-checking bench for pu_sequencer: per-cycle expectations come from the
// latency rules (issue s+1..s+N, clr at s+4, out_valid from s+N+5).
module tb_pu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_chunks = 4'd0;
  logic [7:0] base_addr = 8'd0;
  logic       busy, mem_rd_en, bias_sig, clr;
  logic [7:0] mem_addr;
  logic [7:0] result_in;
  int         cyc = 0;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  pu_sequencer_if out_if ();

  pu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_chunks (num_chunks),
    .base_addr  (base_addr),
    .busy       (busy),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .bias_sig   (bias_sig),
    .clr        (clr),
    .result_in  (result_in),
    .out_if     (out_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign result_in = cyc[7:0];

  typedef struct {
    int n;
    int base;
    int hold;
    bit inject;
    int exp_last_addr;
    int exp_ov_rel;
    int exp_clr_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " mem_rd_en"}, int'(mem_rd_en), 0);
    check({tag, " mem_addr"}, int'(mem_addr), 0);
    check({tag, " bias_sig"}, int'(bias_sig), 0);
    check({tag, " clr"}, int'(clr), 0);
    check({tag, " out_valid"}, int'(out_if.out_valid), 0);
    check({tag, " out_data"}, int'(out_if.out_data), 0);
  endtask

  // Runs one neuron starting in the current cycle; checks every cycle against
  // the latency rules. Entered and left at posedge+1.
  task automatic run_neuron(input int n, input int base, input int hold, input bit inject,
                            output int clr_cnt, output int last_addr, output int ov_rel);
    int s;
    int exp_cap;
    s = cyc;
    exp_cap = (s + n + 4) & 255;
    clr_cnt = 0;
    last_addr = -1;
    ov_rel = -1;
    for (int r = 0; r <= n + 6 + hold; r++) begin
      if (r == 0) begin
        start = 1'b1;
        num_chunks = 4'(n);
        base_addr = 8'(base);
      end else begin
        start = inject && (r <= n + 5 + hold);
        num_chunks = 4'($urandom_range(0, 15));
        base_addr = 8'($urandom_range(0, 255));
      end
      out_if.out_ready = (hold == 0) ? 1'b1 : (r >= n + 5 + hold);
      @(negedge clk);
      check($sformatf("busy r=%0d", r), int'(busy), int'(r >= 1 && r <= n + 5 + hold));
      check($sformatf("rd_en r=%0d", r), int'(mem_rd_en), int'(r >= 1 && r <= n));
      if (r >= 1 && r <= n) begin
        check($sformatf("addr r=%0d", r), int'(mem_addr), (base + r - 1) & 255);
        last_addr = int'(mem_addr);
      end
      check($sformatf("bias r=%0d", r), int'(bias_sig), int'(r == 4));
      check($sformatf("clr r=%0d", r), int'(clr), int'(r == 4));
      if (clr) clr_cnt++;
      check($sformatf("out_valid r=%0d", r), int'(out_if.out_valid),
            int'(r >= n + 5 && r <= n + 5 + hold));
      if (out_if.out_valid) begin
        check($sformatf("out_data r=%0d", r), int'(out_if.out_data), exp_cap);
        if (ov_rel < 0) ov_rel = r;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int c, la, ov;
    run_neuron(v.n, v.base, v.hold, v.inject, c, la, ov);
    check({tag, " clr_count"}, c, v.exp_clr_cnt);
    check({tag, " last_addr"}, la, v.exp_last_addr);
    check({tag, " ov_rel"}, ov, v.exp_ov_rel);
  endtask

  initial begin
    vecs[0] = '{n: 1,  base: 'h20, hold: 0, inject: 1'b0, exp_last_addr: 'h20, exp_ov_rel: 6,  exp_clr_cnt: 1};
    vecs[1] = '{n: 3,  base: 'h10, hold: 0, inject: 1'b0, exp_last_addr: 'h12, exp_ov_rel: 8,  exp_clr_cnt: 1};
    vecs[2] = '{n: 2,  base: 'h40, hold: 5, inject: 1'b1, exp_last_addr: 'h41, exp_ov_rel: 7,  exp_clr_cnt: 1};
    vecs[3] = '{n: 3,  base: 'hFE, hold: 0, inject: 1'b0, exp_last_addr: 'h00, exp_ov_rel: 8,  exp_clr_cnt: 1};
    vecs[4] = '{n: 15, base: 'h80, hold: 0, inject: 1'b0, exp_last_addr: 'h8E, exp_ov_rel: 20, exp_clr_cnt: 1};

    out_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Zero-length request must be ignored.
    start = 1'b1;
    num_chunks = 4'd0;
    base_addr = 8'h55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("zero busy k=%0d", k), int'(busy), 0);
      check($sformatf("zero rd_en k=%0d", k), int'(mem_rd_en), 0);
      start = 1'b0;
      @(posedge clk);
      #1;
    end

    // Reset while draining abandons the neuron.
    start = 1'b1;
    num_chunks = 4'd4;
    base_addr = 8'h30;
    for (int r = 0; r < 6; r++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_all_zero("mid_drain_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("post_rst out_valid k=%0d", k), int'(out_if.out_valid), 0);
      check($sformatf("post_rst busy k=%0d", k), int'(busy), 0);
    end
    @(posedge clk);
    #1;
    run_vec(vecs[0], "after_rst");

    // Randomised neurons against the latency model.
    for (int t = 0; t < 8; t++) begin
      int n, b, h, c, la, ov;
      n = int'($urandom_range(1, 15));
      b = int'($urandom_range(0, 255));
      h = int'($urandom_range(0, 3));
      run_neuron(n, b, h, $urandom_range(0, 1) == 1, c, la, ov);
      check($sformatf("rand%0d clr_count", t), c, 1);
      check($sformatf("rand%0d last_addr", t), la, (b + n - 1) & 255);
      check($sformatf("rand%0d ov_rel", t), ov, n + 5);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pu_sequencer.md
Name: pu_sequencer

Overview:
- Control-side counterpart of the processing-unit datapath. It issues the 8-input operand chunks for one neuron from a synchronous-read operand memory.
- Generates the datapath's bias_sig/clr strobes aligned to the datapath's internal pipeline.
- Captures the 8-bit activated result once the last chunk has been accumulated, and hands it downstream over a valid/ready handshake.
- Sits between the layer controller (start/num_chunks/base_addr) and one processing-unit datapath plus its operand memory.

Parameters:
- CNT_W, 4, width of num_chunks; maximum chunks per neuron is 2^CNT_W-1.
- ADDR_W, 8, operand memory address width.
- RD_LAT, 1, operand memory read latency in cycles (mem_rd_en to data at datapath inputs).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to compute one neuron; sampled only in IDLE.
- num_chunks  in  CNT_W  number of 8-input chunks for the neuron; latched on accepted start.
- base_addr  in  ADDR_W  memory address of chunk 0; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- mem_rd_en  out  1  operand read strobe, one chunk per cycle.
- mem_addr  out  ADDR_W  operand read address.
- bias_sig  out  1  to datapath: add bias term this cycle.
- clr  out  1  to datapath: accumulator loads the tree sum instead of adding it.
- result_in  in  8  datapath activated result (combinational from its accumulator).
- out_valid  out  1  out_data holds a neuron result.
- out_data  out  8  captured neuron result.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; chunk counter, address register and tag pipe cleared. Reset mid-operation abandons the neuron and produces no out_valid.
- Datapath timing contract, for a read issued in cycle t:
  - operands sit in the datapath input registers during t+RD_LAT+1;
  - products are at the adder tree during t+RD_LAT+2;
  - the accumulator updates at the end of that cycle;
  - result_in is valid during t+RD_LAT+3.
- Tag pipe: a shift register of depth RD_LAT+3 carrying {valid, first, last}, pushed each cycle with the tags of the current issue.
  - bias_sig = clr = (valid & first) at stage RD_LAT+2.
  - Capture occurs when (valid & last) is at stage RD_LAT+3.
- FSM states IDLE, ISSUE, DRAIN, OUT.
  - IDLE:
    - start=1 and num_chunks!=0: latch num_chunks and base_addr, go to ISSUE.
    - start with num_chunks==0 is ignored and the state stays IDLE.
  - ISSUE:
    - mem_rd_en=1 every cycle; mem_addr = base_addr + chunk index, wrapping modulo 2^ADDR_W.
    - First issue is tagged first; issue N-1 is tagged last (a single chunk carries both tags).
    - After the last issue, go to DRAIN.
  - DRAIN:
    - mem_rd_en=0.
    - When the last tag reaches the capture stage: out_data <= result_in, go to OUT.
  - OUT:
    - out_valid=1 and out_data stays stable until out_ready=1.
    - On the handshake cycle: out_valid drops next cycle, return to IDLE.
    - Back-to-back neurons therefore cost at least one IDLE cycle.
- start is ignored while busy; latched num_chunks and base_addr do not change mid-neuron.
- out_ready while out_valid=0 has no effect.
- Latency: start accepted in cycle s gives issues in s+1..s+N, bias_sig/clr only in s+RD_LAT+3, capture at the end of s+N+RD_LAT+3, and out_valid from s+N+RD_LAT+4.
- Between neurons bias_sig and clr are 0; the datapath accumulator is only ever cleared via clr on the next neuron's first chunk.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2, OUT=3);
  - the tag field indices;
  - the derived constants TREE_STAGE=RD_LAT+2 and CAP_STAGE=RD_LAT+3.
- One natural sub-module, pu_tag_pipe: a parameterised depth shift register of {valid, first, last} with asynchronous active-low clear. It has its own reset test.
- The FSM and address counter stay in pu_sequencer.

Test Plan (RD_LAT=1, bench models result_in as a per-cycle counter):
- Single chunk:
  - Stimulus: reset, then start in cycle s with num_chunks=1, base_addr=0x20.
  - Required: one read at 0x20 in s+1; bias_sig=clr=1 only in s+4; out_data=result_in(s+5); out_valid from s+6.
- Three chunks, out_ready held at 1:
  - Stimulus: num_chunks=3, base_addr=0x10, out_ready=1.
  - Required: mem_addr 0x10,0x11,0x12 in s+1..s+3; clr high only in s+4; out_valid exactly one cycle at s+8; busy low in s+9.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid rises.
  - Required: out_data stable, a new start ignored, no mem_rd_en; release gives a single handshake.
- Address wrap and zero count:
  - Stimulus: base_addr=0xFE, num_chunks=3; separately num_chunks=0.
  - Required: addresses 0xFE,0xFF,0x00; num_chunks=0 start leaves busy=0 and issues no read.
- Reset mid-DRAIN:
  - Stimulus: assert rst during DRAIN.
  - Required: all outputs 0 immediately; no out_valid afterwards; next start behaves exactly as the single-chunk case.
- Max length:
  - Stimulus: num_chunks=15.
  - Required: 15 contiguous reads; clr exactly once; out_valid at s+20.
